// File: rtl/multicycle_main_control_pkg.sv
// Shared definitions for the multicycle main control unit: state encoding,
// opcodes, ALU/mux select codes and the packed control word.
// Optional feature: MULTICYCLE_ADDI_EN adds the ADDI_EXEC/ADDI_WB states.
package multicycle_main_control_pkg;

  // Opcodes, taken from IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op codes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  // pc_source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // 4-bit state encoding; codes 13-15 are never entered
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StIllegal  = 4'd10,
    StAddiExec = 4'd11,
    StAddiWb   = 4'd12
  } state_e;

  // Full datapath control word driven for one state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_decode.sv
// Combinational state -> control word decoder (Moore outputs).
// Optional feature: MULTICYCLE_ADDI_EN decodes the ADDI states; otherwise
// those codes fall into the all-zero default like any unused state.
module mc_control_decode
  import multicycle_main_control_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  // Every field defaults to 0; each state raises only what it needs
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      StDecode: begin
        // Branch target precompute into ALUOut
        ctrl_o.alu_src_b = ALUSRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemAddr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      StExecute: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StRWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUSRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      StIllegal: begin
        ctrl_o.illegal_op = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      StAddiExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS-subset datapath.
// Holds the state register, the opcode latched at DECODE exit and the
// next-state logic; outputs are decoded from state alone.
// Optional feature: MULTICYCLE_ADDI_EN enables the ADDI path (opcode 001000).
module multicycle_main_control
  import multicycle_main_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  ctrl_t      ctrl;

  // Next state; MEM_ADDR looks at the latched opcode since IR may have moved on
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = StAddiExec;
`endif
          default:      state_d = StIllegal;
        endcase
      end
      StMemAddr: state_d = (opcode_q == OP_LW) ? StMemRead : StMemWrite;
      StMemRead: state_d = StMemWb;
      StExecute: state_d = StRWb;
`ifdef MULTICYCLE_ADDI_EN
      StAddiExec: state_d = StAddiWb;
`endif
      // MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ILLEGAL and unused codes
      default:   state_d = StFetch;
    endcase
  end

  // State register and opcode latch; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opcode_q <= opcode;
      end
    end
  end

  mc_control_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// through its state sequence and compares state plus the full control word
// against hand-written expectations.
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // pw pwc iod mr mw irw m2r rd rw asa asb aop psrc ill
  localparam logic [17:0] CW_FETCH   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [17:0] CW_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [17:0] CW_MADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] CW_MREAD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] CW_MWB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [17:0] CW_MWRITE  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] CW_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [17:0] CW_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [17:0] CW_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] CW_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [17:0] CW_ILLEGAL = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
  localparam logic [17:0] CW_AEXEC   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] CW_AWB     = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  logic [17:0] cw;
  assign cw = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  multicycle_main_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st, input logic [17:0] w);
    check({tag, ".state"}, {28'd0, state}, {28'd0, st});
    check({tag, ".ctrl"}, {14'd0, cw}, {14'd0, w});
  endtask

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    #1;
    expect_state("reset", 4'd0, CW_FETCH);
    #10;
    rst_n = 1'b1;

    // LW: 0,1,2,3,4,0; IR changes during MEM_ADDR must not matter
    opcode = 6'b100011;
    expect_state("lw_fetch", 4'd0, CW_FETCH);
    tick(); expect_state("lw_decode", 4'd1, CW_DECODE);
    tick(); expect_state("lw_addr", 4'd2, CW_MADDR);
    opcode = 6'b000000;
    tick(); expect_state("lw_read", 4'd3, CW_MREAD);
    tick(); expect_state("lw_wb", 4'd4, CW_MWB);
    tick(); expect_state("lw_done", 4'd0, CW_FETCH);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    tick(); expect_state("r_decode", 4'd1, CW_DECODE);
    tick(); expect_state("r_exec", 4'd6, CW_EXEC);
    tick(); expect_state("r_wb", 4'd7, CW_RWB);
    tick(); expect_state("r_done", 4'd0, CW_FETCH);

    // BEQ: 0,1,8,0
    opcode = 6'b000100;
    tick(); expect_state("beq_decode", 4'd1, CW_DECODE);
    tick(); expect_state("beq_branch", 4'd8, CW_BRANCH);
    tick(); expect_state("beq_done", 4'd0, CW_FETCH);

    // SW with IR switched to J during MEM_ADDR, then the J itself
    opcode = 6'b101011;
    tick(); expect_state("sw_decode", 4'd1, CW_DECODE);
    tick(); expect_state("sw_addr", 4'd2, CW_MADDR);
    opcode = 6'b000010;
    tick(); expect_state("sw_write", 4'd5, CW_MWRITE);
    tick(); expect_state("sw_done", 4'd0, CW_FETCH);
    tick(); expect_state("j_decode", 4'd1, CW_DECODE);
    tick(); expect_state("j_jump", 4'd9, CW_JUMP);
    tick(); expect_state("j_done", 4'd0, CW_FETCH);

    // Unsupported opcode: one-cycle illegal_op
    opcode = 6'b111111;
    tick(); expect_state("ill_decode", 4'd1, CW_DECODE);
    tick(); expect_state("ill_pulse", 4'd10, CW_ILLEGAL);
    tick(); expect_state("ill_done", 4'd0, CW_FETCH);

    // ADDI opcode: own path when enabled, illegal otherwise
    opcode = 6'b001000;
    tick(); expect_state("addi_decode", 4'd1, CW_DECODE);
`ifdef MULTICYCLE_ADDI_EN
    tick(); expect_state("addi_exec", 4'd11, CW_AEXEC);
    tick(); expect_state("addi_wb", 4'd12, CW_AWB);
`else
    tick(); expect_state("addi_illegal", 4'd10, CW_ILLEGAL);
`endif
    tick(); expect_state("addi_done", 4'd0, CW_FETCH);

    // Reset asserted mid-EXECUTE clears state before the next edge
    opcode = 6'b000000;
    tick(); expect_state("rst_decode", 4'd1, CW_DECODE);
    tick(); expect_state("rst_exec", 4'd6, CW_EXEC);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("rst_async", 4'd0, CW_FETCH);
    #2;
    rst_n = 1'b1;
    expect_state("rst_release", 4'd0, CW_FETCH);
    tick(); expect_state("rst_restart", 4'd1, CW_DECODE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore FSM main control unit for the multicycle MIPS-subset datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback steps.
- Drives every datapath enable and mux select, plus the 2-bit alu_op consumed by the downstream ALU control decoder (00 add, 01 sub, 10 use funct).
- Sits between the instruction register opcode field and the datapath control inputs.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; sampled only in DECODE
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address mux: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback mux: 0=ALUOut, 1=MDR
reg_dst  out  1  dest reg mux: 0=rt, 1=rd
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  to ALU control: 00 add, 01 sub, 10 funct
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state, for debug/trace

Behaviour:
- One state register, asynchronous clear to FETCH on rst_n low; advances on rising clk. All outputs are pure combinational functions of state only (Moore); no output depends on opcode.
- Reset: state=FETCH (0); outputs take FETCH values immediately while rst_n is low.
- Reset asserted mid-instruction aborts it. No partial writeback; next instruction starts from FETCH.
- Defaults: every output not listed for a state is 0.
- FETCH (0): mem_read, ir_write, alu_src_b=01, alu_op=00, pc_write, pc_source=00. Next: DECODE.
- DECODE (1): alu_src_b=11, alu_op=00 (branch target precompute). Next by opcode:
  - LW/SW -> MEM_ADDR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - J -> JUMP
  - any other -> ILLEGAL
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_READ if opcode latched as LW, else MEM_WRITE. Opcode is registered at DECODE exit; IR may change later.
- MEM_READ (3): mem_read, i_or_d=1 -> MEM_WB.
- MEM_WB (4): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE (5): mem_write, i_or_d=1 -> FETCH.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB (7): reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01 -> FETCH.
- JUMP (9): pc_write, pc_source=10 -> FETCH.
- ILLEGAL (10): illegal_op=1, no writes -> FETCH. The instruction is skipped; PC already advanced in FETCH.
- Unused state codes (11-15, or 13-15 with the optional feature) -> FETCH next cycle, all outputs 0.
- Cycle counts, FETCH to next FETCH: LW 5, SW 4, R-type 4, BEQ 3, J 3, illegal 3.
- mem_read and mem_write are never both 1. pc_write and pc_write_cond are never both 1.

Optional Feature:
MULTICYCLE_ADDI_EN
- Defined: opcode 6'b001000 in DECODE -> ADDI_EXEC (11), then ADDI_WB (12), then FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0.
  - Total 4 cycles.
- Undefined: 6'b001000 is illegal and takes the ILLEGAL path.

Decomposition:
- Shared package holds: state encoding constants (FETCH..ADDI_WB, 4-bit), opcode constants, alu_op codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), alu_src_b and pc_source select codes.
- One natural sub-module: mc_control_decode, a combinational state -> control-word decoder. The top module keeps the state register, latched opcode and next-state logic.

Test Plan:
- Reset: rst_n low mid-EXECUTE -> state=0 asynchronously, before the next clk; after release, FETCH outputs: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- LW (opcode 100011) -> state sequence 0,1,2,3,4,0; alu_op=00 throughout; reg_write=1 and mem_to_reg=1 only in state 4.
- R-type (000000) -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 with reg_write=1 in state 7.
- BEQ (000100) -> states 0,1,8,0; in state 8: alu_op=01, pc_write_cond=1, pc_source=01.
- SW then J back-to-back; IR opcode changed during MEM_ADDR -> SW still reaches state 5 (mem_write=1, i_or_d=1); J gives states 0,1,9 with pc_source=10.
- Opcode 111111 -> illegal_op=1 for exactly one cycle, no reg_write/mem_write, then back to FETCH. Opcode 001000 is illegal without MULTICYCLE_ADDI_EN; with it, states 0,1,11,12,0.
